// File: rtl/des_key_sched_dec.sv
// DES decryption key schedule: takes the post-PC-1 halves C0/D0 and streams the 16 round
// subkeys K16..K1 over a valid/ready handshake, one subkey per accepted beat.
// Halves and subkey use descending vectors; FIPS 46-3 bit 1 is the MSB
// (c_in[27], d_in[27], subkey[47]).
// Optional build macro DES_KEYSCHED_BIDIR_EN adds an `encrypt` input that selects K1..K16 order.
module des_key_sched_dec #(
  parameter bit CLEAR_ON_DONE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef DES_KEYSCHED_BIDIR_EN
  input  logic        encrypt,
`endif
  input  logic [27:0] c_in,
  input  logic [27:0] d_in,
  output logic        busy,
  output logic        sub_valid,
  input  logic        sub_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round_idx,
  output logic        last,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StEmit, StDone} stateT;

  stateT       state, stateNext;
  logic [3:0]  cnt, cntNext;
  logic [27:0] c_reg, d_reg, cNext, dNext;
  logic        encMode;  // held direction for the running sequence
  logic        loadEnc;  // direction requested at load time
  logic        shiftTwo;
  logic [55:0] cd;

  function automatic logic [27:0] rotR(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  function automatic logic [27:0] rotL(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

`ifdef DES_KEYSCHED_BIDIR_EN
  assign loadEnc = encrypt;

  // Latch the direction at load so it stays fixed for the whole sequence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      encMode <= 1'b0;
    end else if (state == StIdle && start) begin
      encMode <= encrypt;
    end
  end
`else
  assign loadEnc = 1'b0;
  assign encMode = 1'b0;
`endif

  // Steps after beats 0, 7 and 14 shift by one; all others by two (same table both directions)
  assign shiftTwo = !(cnt == 4'd0 || cnt == 4'd7 || cnt == 4'd14);

  // Next-state logic: load, rotate on each accepted beat, finish after the 16th beat
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    cNext     = c_reg;
    dNext     = d_reg;
    unique case (state)
      StIdle: begin
        if (start) begin
          stateNext = StEmit;
          cntNext   = 4'd0;
          // Decryption starts from C16 = C0; encryption starts from C1 = C0 <<< 1
          cNext     = loadEnc ? rotL(c_in, 1'b0) : c_in;
          dNext     = loadEnc ? rotL(d_in, 1'b0) : d_in;
        end
      end
      StEmit: begin
        if (sub_ready) begin
          if (cnt == 4'd15) begin
            stateNext = StDone;
            if (CLEAR_ON_DONE) begin
              cNext = '0;
              dNext = '0;
            end
          end else begin
            cntNext = cnt + 4'd1;
            cNext   = encMode ? rotL(c_reg, shiftTwo) : rotR(c_reg, shiftTwo);
            dNext   = encMode ? rotL(d_reg, shiftTwo) : rotR(d_reg, shiftTwo);
          end
        end
      end
      StDone: begin
        stateNext = StIdle;
      end
      default: begin
        stateNext = StIdle;
      end
    endcase
  end

  // State, beat counter and key-half registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StIdle;
      cnt   <= 4'd0;
      c_reg <= '0;
      d_reg <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      c_reg <= cNext;
      d_reg <= dNext;
    end
  end

  // PC-2 selection; cd[56-n] is FIPS bit n of C||D, subkey MSB is FIPS bit 1
  assign cd = {c_reg, d_reg};

  always_comb begin
    subkey = {
      cd[56-14], cd[56-17], cd[56-11], cd[56-24], cd[56-1],  cd[56-5],
      cd[56-3],  cd[56-28], cd[56-15], cd[56-6],  cd[56-21], cd[56-10],
      cd[56-23], cd[56-19], cd[56-12], cd[56-4],  cd[56-26], cd[56-8],
      cd[56-16], cd[56-7],  cd[56-27], cd[56-20], cd[56-13], cd[56-2],
      cd[56-41], cd[56-52], cd[56-31], cd[56-37], cd[56-47], cd[56-55],
      cd[56-30], cd[56-40], cd[56-51], cd[56-45], cd[56-33], cd[56-48],
      cd[56-44], cd[56-49], cd[56-39], cd[56-56], cd[56-34], cd[56-53],
      cd[56-46], cd[56-42], cd[56-50], cd[56-36], cd[56-29], cd[56-32]
    };
  end

  // Handshake and status outputs decoded from state and beat counter
  always_comb begin
    sub_valid = (state == StEmit);
    busy      = (state == StEmit);
    last      = (state == StEmit) && (cnt == 4'd15);
    done      = (state == StDone);
    // Round 16 wraps to 4'd0 in either direction
    round_idx = encMode ? (cnt + 4'd1) : (4'd0 - cnt);
  end

endmodule

// File: tb/tb_des_key_sched_dec.sv
// Bench for des_key_sched_dec: FIPS-level key schedule model (cumulative left shifts + PC-2),
// one negedge compare process, directed stimulus with literal pins from the FIPS worked example.
module tb_des_key_sched_dec;

  localparam logic [27:0] C0 = 28'hF0CCAAF;
  localparam logic [27:0] D0 = 28'h556678F;
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int LSHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [27:0] cIn = '0;
  logic [27:0] dIn = '0;
  logic        subReady = 1'b0;
  logic        busy, subValid, last, done;
  logic [47:0] subkey;
  logic [3:0]  roundIdx;
  logic        kBusy, kValid, kLast, kDone;
  logic [47:0] kSubkey;
  logic [3:0]  kRoundIdx;
`ifdef DES_KEYSCHED_BIDIR_EN
  logic        encrypt = 1'b0;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  logic [47:0] expKey [16];
  logic [3:0]  expRound [16];
  int          expIdx = 0;
  bit          checkEn = 1'b0;
  bit          pendDone = 1'b0;
  bit          seqDone = 1'b0;

  always #5 clk = ~clk;

  des_key_sched_dec dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef DES_KEYSCHED_BIDIR_EN
    .encrypt   (encrypt),
`endif
    .c_in      (cIn),
    .d_in      (dIn),
    .busy      (busy),
    .sub_valid (subValid),
    .sub_ready (subReady),
    .subkey    (subkey),
    .round_idx (roundIdx),
    .last      (last),
    .done      (done)
  );

  des_key_sched_dec #(.CLEAR_ON_DONE(1'b0)) dutKeep (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef DES_KEYSCHED_BIDIR_EN
    .encrypt   (encrypt),
`endif
    .c_in      (cIn),
    .d_in      (dIn),
    .busy      (kBusy),
    .sub_valid (kValid),
    .sub_ready (subReady),
    .subkey    (kSubkey),
    .round_idx (kRoundIdx),
    .last      (kLast),
    .done      (kDone)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [27:0] rotl(input logic [27:0] x, input int n);
    logic [55:0] t;
    t = {x, x};
    return 28'(t >> (28 - n));
  endfunction

  function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
    logic [55:0] cdv;
    logic [47:0] k;
    cdv = {c, d};
    k = '0;
    for (int i = 0; i < 48; i++) k = {k[46:0], 1'(cdv >> (56 - PC2[i]))};
    return k;
  endfunction

  // Kn = PC-2 of C0/D0 rotated left by the cumulative FIPS shift count up to round n
  task automatic buildModel(input logic [27:0] c0, input logic [27:0] d0, input bit enc);
    logic [47:0] ks [16];
    int cum;
    cum = 0;
    for (int n = 0; n < 16; n++) begin
      cum += LSHIFT[n];
      ks[n] = pc2(rotl(c0, cum % 28), rotl(d0, cum % 28));
    end
    for (int k = 0; k < 16; k++) begin
      if (enc) begin
        expKey[k]   = ks[k];
        expRound[k] = 4'((k + 1) % 16);
      end else begin
        expKey[k]   = ks[15 - k];
        expRound[k] = 4'((16 - k) % 16);
      end
    end
  endtask

  // Compare process: every cycle of an active sequence, against the model
  initial forever begin
    @(negedge clk);
    if (checkEn && !rst) begin
      if (pendDone) begin
        check("done pulse", 64'(done), 64'd1);
        check("valid low in done", 64'(subValid), 64'd0);
        check("busy low in done", 64'(busy), 64'd0);
        check("keep done pulse", 64'(kDone), 64'd1);
        check("keep busy/valid in done", 64'({kBusy, kValid}), 64'd0);
        pendDone = 1'b0;
        seqDone  = 1'b1;
      end else if (!seqDone) begin
        check("sub_valid", 64'(subValid), 64'd1);
        check("busy", 64'(busy), 64'd1);
        check("done low", 64'(done), 64'd0);
        check("subkey", 64'(subkey), 64'(expKey[expIdx]));
        check("round_idx", 64'(roundIdx), 64'(expRound[expIdx]));
        check("last", 64'(last), 64'(expIdx == 15));
        check("keep subkey", 64'(kSubkey), 64'(expKey[expIdx]));
        check("keep round_idx", 64'(kRoundIdx), 64'(expRound[expIdx]));
        check("keep last", 64'(kLast), 64'(expIdx == 15));
        if (subReady) begin
          if (expIdx == 15) pendDone = 1'b1;
          else expIdx++;
        end
      end
    end
  end

  task automatic setEnc(input bit enc);
`ifdef DES_KEYSCHED_BIDIR_EN
    encrypt = enc;
`else
    if (enc) $display("note: encrypt requested without DES_KEYSCHED_BIDIR_EN");
`endif
  endtask

  // One full sequence; start is also pulsed in DONE (and optionally mid-EMIT) to prove it is ignored
  task automatic runSeq(input bit randReady, input bit enc, input bit injectStart);
    buildModel(C0, D0, enc);
    expIdx   = 0;
    pendDone = 1'b0;
    seqDone  = 1'b0;
    @(posedge clk);
    #1;
    cIn = C0;
    dIn = D0;
    setEnc(enc);
    start = 1'b1;
    subReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("first beat valid after start", 64'(subValid), 64'd1);
    check("first subkey", 64'(subkey), 64'(expKey[0]));
    checkEn = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (seqDone) break;
      #1;
      subReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      start = pendDone || (injectStart && i == 3);
      if (injectStart && i == 3) begin
        cIn = ~C0;
        dIn = ~D0;
      end
    end
    #1;
    start = 1'b0;
    checkEn = 1'b0;
    check("sequence completes", 64'(seqDone), 64'd1);
    check("start in DONE ignored", 64'({busy, subValid}), 64'd0);
    check("done one cycle only", 64'(done), 64'd0);
  endtask

  initial begin
    // Async reset before any clock edge
    #1 rst = 1'b1;
    #2;
    check("reset outputs", 64'({busy, subValid, last, done}), 64'd0);
    check("reset subkey", 64'(subkey), 64'd0);
    check("reset round_idx", 64'(roundIdx), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Pin the model to the FIPS worked example
    buildModel(C0, D0, 1'b0);
    check("model K16", 64'(expKey[0]), 64'h0000_CB3D8B0E17F5);
    check("model K1", 64'(expKey[15]), 64'h0000_1B02EFFC7072);
    check("model last round", 64'(expRound[15]), 64'd1);

    // Back-to-back beats, then key hygiene on both instances
    runSeq(1'b0, 1'b0, 1'b0);
    check("cleared c_reg", 64'(dut.c_reg), 64'd0);
    check("cleared d_reg", 64'(dut.d_reg), 64'd0);
    check("kept c_reg", 64'(dutKeep.c_reg), 64'h0E19955F);
    check("kept d_reg", 64'(dutKeep.d_reg), 64'h0AACCF1E);

    // Random stalls with a stray start and input change mid-sequence
    runSeq(1'b1, 1'b0, 1'b1);

    // Reset while the 7th subkey is presented
    buildModel(C0, D0, 1'b0);
    @(posedge clk);
    #1;
    cIn = C0;
    dIn = D0;
    setEnc(1'b0);
    start = 1'b1;
    subReady = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("7th subkey before reset", 64'(subkey), 64'(expKey[6]));
    #1 rst = 1'b1;
    #1;
    check("mid reset outputs", 64'({busy, subValid, last, done}), 64'd0);
    check("mid reset subkey", 64'(subkey), 64'd0);
    check("mid reset round_idx", 64'(roundIdx), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    runSeq(1'b1, 1'b0, 1'b0);

`ifdef DES_KEYSCHED_BIDIR_EN
    buildModel(C0, D0, 1'b1);
    check("enc model K1", 64'(expKey[0]), 64'h0000_1B02EFFC7072);
    check("enc model K16", 64'(expKey[15]), 64'h0000_CB3D8B0E17F5);
    runSeq(1'b1, 1'b1, 1'b0);
    runSeq(1'b0, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
